// File: rtl/rr_arb8.sv
// rr_arb8: 8-way round-robin arbiter with a rotating priority pointer and an optional hold limit.
// All outputs are registered: a one-hot grant, its binary index, a valid flag and a preempt pulse.
module rr_arb8 #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] gnt_idx,
   output logic       gnt_vld,
   output logic       preempt
);

   typedef enum logic {IDLE, GRANT} state_e;

   localparam bit         HoldEn   = (MAX_HOLD != 0);
   localparam logic [7:0] HoldLast = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

   state_e     state_q, state_d;
   logic [7:0] gnt_q, gnt_d;
   logic [2:0] idx_q, idx_d;
   logic [2:0] ptr_q, ptr_d;
   logic [7:0] cnt_q, cnt_d;
   logic       preempt_q, preempt_d;

   logic [2:0] nextPtr;
   logic [7:0] others;
   logic       timeout;

   // First set bit of v, searching upward from p and wrapping past 7.
   function automatic logic [2:0] sel(input logic [7:0] v, input logic [2:0] p);
      logic [2:0] pick;
      logic [2:0] cand;
      logic       found;
      pick  = p;
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
         cand = p + 3'(k);
         if (!found && v[cand]) begin
            pick  = cand;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         gnt_q     <= 8'd0;
         idx_q     <= 3'd0;
         ptr_q     <= 3'd0;
         cnt_q     <= 8'd0;
         preempt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         idx_q     <= idx_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         preempt_q <= preempt_d;
      end
   end

   // Release takes precedence over timeout; while in GRANT, gnt_q is the one-hot of idx_q.
   always_comb begin
      nextPtr   = idx_q + 3'd1;
      others    = req & ~gnt_q;
      timeout   = HoldEn && (cnt_q == HoldLast);
      state_d   = state_q;
      gnt_d     = gnt_q;
      idx_d     = idx_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      preempt_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (en && (|req)) begin
               idx_d   = sel(req, ptr_q);
               gnt_d   = 8'd1 << idx_d;
               cnt_d   = 8'd0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (!req[idx_q]) begin
               ptr_d = nextPtr;
               if (en && (|req)) begin
                  idx_d = sel(req, nextPtr);
                  gnt_d = 8'd1 << idx_d;
                  cnt_d = 8'd0;
               end else begin
                  gnt_d   = 8'd0;
                  state_d = IDLE;
               end
            end else if (timeout) begin
               preempt_d = 1'b1;
               ptr_d     = nextPtr;
               cnt_d     = 8'd0;
               if (en && (|others)) begin
                  idx_d = sel(others, nextPtr);
                  gnt_d = 8'd1 << idx_d;
               end
            end else if (cnt_q != HoldLast) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign gnt     = gnt_q;
   assign gnt_idx = idx_q;
   assign gnt_vld = |gnt_q;
   assign preempt = preempt_q;

endmodule

// File: tb/tb_rr_arb8.sv
// tb_rr_arb8: directed scenarios with literal expectations plus randomized traffic,
// all checked every cycle against a behavioural round-robin model.
module tb_rr_arb8;

   localparam int HOLD = 4;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [7:0] req;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_vld;
   logic       preempt;

   int tests = 0;
   int fails = 0;
   bit checkEn = 0;

   // Model state: whether a grant is active, who holds it, how long it has been held.
   bit mBusy = 0;
   int mG    = 0;
   int mIdx  = 0;
   int mPtr  = 0;
   int mHeld = 0;
   bit mPre  = 0;

   int grantsSeen [8];

   rr_arb8 #(.MAX_HOLD(HOLD)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .req     (req),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld),
      .preempt (preempt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int selModel(input logic [7:0] v, input int p);
      for (int k = 0; k < 8; k++) begin
         if (v[(p + k) % 8]) return (p + k) % 8;
      end
      return p;
   endfunction

   // Reference model: advances on every rising edge using the sampled inputs.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mBusy <= 0;
         mG    <= 0;
         mIdx  <= 0;
         mPtr  <= 0;
         mHeld <= 0;
         mPre  <= 0;
      end else begin
         automatic bit         busy = mBusy;
         automatic int         g    = mG;
         automatic int         idx  = mIdx;
         automatic int         ptr  = mPtr;
         automatic int         held = mHeld;
         automatic bit         pre  = 0;
         automatic logic [7:0] rest;
         rest = req;
         rest[mG] = 1'b0;
         if (!busy) begin
            if (en && req != 8'd0) begin
               g = selModel(req, ptr); idx = g; busy = 1; held = 1;
            end
         end else if (!req[g]) begin
            ptr = (g + 1) % 8;
            if (en && req != 8'd0) begin
               g = selModel(req, ptr); idx = g; held = 1;
            end else begin
               busy = 0;
            end
         end else if (HOLD != 0 && held == HOLD) begin
            pre = 1;
            ptr = (g + 1) % 8;
            if (en && rest != 8'd0) begin
               g = selModel(rest, ptr); idx = g;
            end
            held = 1;
         end else begin
            held = held + 1;
         end
         mBusy <= busy;
         mG    <= g;
         mIdx  <= idx;
         mPtr  <= ptr;
         mHeld <= held;
         mPre  <= pre;
      end
   end

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
      end
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("model_gnt", gnt, mBusy ? (8'd1 << mG) : 8'd0);
         checkOutput("model_idx", {5'd0, gnt_idx}, 8'(mIdx));
         checkOutput("model_vld", {7'd0, gnt_vld}, {7'd0, mBusy});
         checkOutput("model_preempt", {7'd0, preempt}, {7'd0, mPre});
      end
   end

   // Drive inputs just after a falling edge, then wait until the next falling edge.
   task automatic applyStimulus(input logic [7:0] r, input logic e);
      req = r;
      en  = e;
      @(negedge clk);
   endtask

   task automatic resetDut();
      @(negedge clk);
      rst_n = 1'b0;
      req   = 8'd0;
      en    = 1'b0;
      @(negedge clk);
      checkOutput("reset_gnt", gnt, 8'h00);
      checkOutput("reset_idx", {5'd0, gnt_idx}, 8'h00);
      checkOutput("reset_vld", {7'd0, gnt_vld}, 8'h00);
      checkOutput("reset_preempt", {7'd0, preempt}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 8'd0;
      en    = 1'b0;
      repeat (2) @(negedge clk);
      checkEn = 1;

      // Single request, then release: pointer moves past the released index.
      resetDut();
      applyStimulus(8'h04, 1'b1);
      checkOutput("single_gnt", gnt, 8'h04);
      checkOutput("single_idx", {5'd0, gnt_idx}, 8'd2);
      checkOutput("single_vld", {7'd0, gnt_vld}, 8'd1);
      applyStimulus(8'h00, 1'b1);
      checkOutput("release_gnt", gnt, 8'h00);
      checkOutput("release_idx_hold", {5'd0, gnt_idx}, 8'd2);
      applyStimulus(8'hFF, 1'b1);
      checkOutput("ptr_after_release", {5'd0, gnt_idx}, 8'd3);

      // Back-to-back handover from 1 to 5 without an idle cycle.
      resetDut();
      applyStimulus(8'h22, 1'b1);
      checkOutput("b2b_first", {5'd0, gnt_idx}, 8'd1);
      applyStimulus(8'h20, 1'b1);
      checkOutput("b2b_second", {5'd0, gnt_idx}, 8'd5);
      checkOutput("b2b_vld", {7'd0, gnt_vld}, 8'd1);

      // Fairness with every requester active: each index holds for HOLD cycles in turn.
      resetDut();
      for (int i = 0; i < 8; i++) grantsSeen[i] = 0;
      req = 8'hFF;
      en  = 1'b1;
      for (int n = 0; n < 32; n++) begin
         @(negedge clk);
         checkOutput("fair_idx", {5'd0, gnt_idx}, 8'((n / 4) % 8));
         checkOutput("fair_preempt", {7'd0, preempt}, (n > 0 && n % 4 == 0) ? 8'd1 : 8'd0);
         if (n % 4 == 0) grantsSeen[gnt_idx]++;
      end
      for (int i = 0; i < 8; i++) checkOutput("fair_once", 8'(grantsSeen[i]), 8'd1);

      // Sole requester keeps its grant across timeouts, with a preempt pulse each period.
      resetDut();
      req = 8'h40;
      en  = 1'b1;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         checkOutput("sole_gnt", gnt, 8'h40);
         checkOutput("sole_preempt", {7'd0, preempt}, (n > 0 && n % 4 == 0) ? 8'd1 : 8'd0);
      end

      // Pointer wrap from 7, with enable low blocking new grants.
      resetDut();
      applyStimulus(8'h80, 1'b1);
      checkOutput("wrap_first", {5'd0, gnt_idx}, 8'd7);
      applyStimulus(8'h81, 1'b0);
      checkOutput("wrap_hold", gnt, 8'h80);
      applyStimulus(8'h81, 1'b0);
      checkOutput("wrap_hold2", {5'd0, gnt_idx}, 8'd7);
      applyStimulus(8'h01, 1'b0);
      checkOutput("wrap_idle", gnt, 8'h00);
      checkOutput("wrap_idle_vld", {7'd0, gnt_vld}, 8'd0);
      applyStimulus(8'h01, 1'b1);
      checkOutput("wrap_next", {5'd0, gnt_idx}, 8'd0);
      checkOutput("wrap_next_gnt", gnt, 8'h01);

      // Asynchronous reset in the middle of a grant.
      resetDut();
      applyStimulus(8'h10, 1'b1);
      checkOutput("async_pre_gnt", gnt, 8'h10);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_gnt", gnt, 8'h00);
      checkOutput("async_vld", {7'd0, gnt_vld}, 8'd0);
      checkOutput("async_preempt", {7'd0, preempt}, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(8'h11, 1'b1);
      checkOutput("async_after", {5'd0, gnt_idx}, 8'd0);
      checkOutput("async_after_gnt", gnt, 8'h01);

      // Randomized traffic with sticky requests and mostly-high enable.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(3) == 0) begin
            if ($urandom_range(1) == 0) req = 8'($urandom);
            else req = 8'($urandom) & 8'($urandom);
         end
         en = ($urandom_range(7) != 0);
         @(negedge clk);
      end

      checkEn = 0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
